// File: rtl/fib_pkg.sv
// fib_pkg: shared constants and types for the fib circuit.
// Holds the FSM state encoding, the datapath widths (the BCD converter also
// imports FIB_W from here), the overflow threshold and the saturation value.
package fib_pkg;

  // Result width: fib(23) = 28657 is the largest value that fits exactly.
  localparam int unsigned FIB_W       = 15;
  // Index width: indices 0..31.
  localparam int unsigned IDX_W       = 5;
  // First index whose Fibonacci value no longer fits in FIB_W bits.
  localparam int unsigned FIB_OVF_IDX = 24;
  // Saturated result reported for out-of-range indices.
  localparam logic [FIB_W-1:0] FIB_SAT = 15'h7FFF;

  // Engine states.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OP      = 2'b01,
    DONE    = 2'b10,
    HANDOFF = 2'b11
  } fib_state_t;

  // Result payload presented to the BCD converter.
  typedef struct packed {
    logic             ovf;
    logic [FIB_W-1:0] f;
  } fib_result_t;

endpackage

// File: rtl/fib_calc.sv
// fib_calc: iterative Fibonacci engine.
// Computes fib(i) as a 15-bit unsigned value (mod 2^15) with one adder and a
// down-counter, then hands it to the downstream BCD converter through a
// start/ready handshake.
//
// Optional feature macro: FIB_OVF_SAT_EN
//   defined   - indices >= 24 saturate f to 0x7FFF, set ovf, skip iterating.
//   undefined - no range check; result wraps mod 2^15 and ovf stays 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   computation request, sampled only in IDLE
//   i          in   Fibonacci index 0..31, captured with start
//   bcd_ready  in   downstream BCD converter ready
//   ready      out  high only in IDLE (decoded from state)
//   done_tick  out  one-cycle pulse while in DONE
//   f          out  result, held until the next accepted start
//   ovf        out  overflow flag, valid with f
//   bcd_start  out  start pulse to the BCD converter (HANDOFF and bcd_ready)
module fib_calc
  import fib_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] i,
  input  logic             bcd_ready,
  output logic             ready,
  output logic             done_tick,
  output logic [FIB_W-1:0] f,
  output logic             ovf,
  output logic             bcd_start
);

  fib_state_t       state;
  logic [FIB_W-1:0] t0;
  logic [FIB_W-1:0] t1;
  logic [IDX_W-1:0] n;
  fib_result_t      res;
  logic             done_q;

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      t0     <= '0;
      t1     <= '0;
      n      <= '0;
      res    <= '0;
      done_q <= 1'b0;
    end else begin
      // done_q is asserted only on the edge that enters DONE.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef FIB_OVF_SAT_EN
            if (i >= IDX_W'(FIB_OVF_IDX)) begin
              res.f   <= FIB_SAT;
              res.ovf <= 1'b1;
              state   <= DONE;
              done_q  <= 1'b1;
            end else
`endif
            begin
              t0      <= '0;
              t1      <= FIB_W'(1);
              n       <= i;
              res.ovf <= 1'b0;
              state   <= OP;
            end
          end
        end

        OP: begin
          if (n == '0) begin
            res.f  <= '0;
            state  <= DONE;
            done_q <= 1'b1;
          end else if (n == IDX_W'(1)) begin
            res.f  <= t1;
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            // Carry out of bit 14 is discarded: results wrap mod 2^15.
            t1 <= t1 + t0;
            t0 <= t1;
            n  <= n - IDX_W'(1);
          end
        end

        DONE: begin
          state <= HANDOFF;
        end

        HANDOFF: begin
          // Leave on the same cycle bcd_start is presented.
          if (bcd_ready) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready     = (state == IDLE);
  assign bcd_start = (state == HANDOFF) && bcd_ready;
  assign done_tick = done_q;
  assign f         = res.f;
  assign ovf       = res.ovf;

endmodule

// File: tb/tb_fib_calc.sv
// tb_fib_calc: directed self-checking bench for fib_calc.
// Build with +define+FIB_OVF_SAT_EN to check the saturating configuration.
module tb_fib_calc;
  import fib_pkg::*;

  logic             clk;
  logic             reset;
  logic             start;
  logic [IDX_W-1:0] i;
  logic             bcd_ready;
  logic             ready;
  logic             done_tick;
  logic [FIB_W-1:0] f;
  logic             ovf;
  logic             bcd_start;

  int n_cmp = 0;
  int n_bad = 0;

  fib_calc dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .i         (i),
    .bcd_ready (bcd_ready),
    .ready     (ready),
    .done_tick (done_tick),
    .f         (f),
    .ovf       (ovf),
    .bcd_start (bcd_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Raise start at a falling edge and count rising edges, starting with the
  // one that samples start, until done_tick is seen (bounded).
  task automatic run_fib(input logic [IDX_W-1:0] idx, output int lat);
    @(negedge clk);
    i     = idx;
    start = 1'b1;
    lat   = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
    end while (!done_tick && lat < 100);
  endtask

  // With bcd_ready already high: one bcd_start cycle, then ready again.
  task automatic finish_handoff(input string tag);
    @(negedge clk);
    check_eq({tag, "_bcd_start"}, 32'(bcd_start), 32'd1);
    check_eq({tag, "_ready_busy"}, 32'(ready), 32'd0);
    check_eq({tag, "_done_once"}, 32'(done_tick), 32'd0);
    @(negedge clk);
    check_eq({tag, "_ready_back"}, 32'(ready), 32'd1);
    check_eq({tag, "_bcd_start_off"}, 32'(bcd_start), 32'd0);
  endtask

  task automatic run_case(input string tag, input logic [IDX_W-1:0] idx,
                          input logic [FIB_W-1:0] exp_f, input logic exp_ovf,
                          input int exp_lat);
    int lat;
    run_fib(idx, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_f"}, 32'(f), 32'(exp_f));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    finish_handoff(tag);
  endtask

  initial begin
    int lat;
    int pulses;

    reset     = 1'b0;
    start     = 1'b0;
    i         = '0;
    bcd_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done_tick), 32'd0);
    check_eq("rst_bcd_start", 32'(bcd_start), 32'd0);
    check_eq("rst_f", 32'(f), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b1;

    run_case("i0", 5'd0, 15'd0, 1'b0, 2);
    run_case("i1", 5'd1, 15'd1, 1'b0, 2);
    run_case("i10", 5'd10, 15'd55, 1'b0, 11);
    run_case("i23", 5'd23, 15'h6FF1, 1'b0, 24);
`ifdef FIB_OVF_SAT_EN
    run_case("i24", 5'd24, 15'h7FFF, 1'b1, 1);
`else
    run_case("i24", 5'd24, 15'h3520, 1'b0, 25);
`endif

    // Handoff stall: converter busy for 5 cycles, start pulses ignored.
    bcd_ready = 1'b0;
    run_fib(5'd5, lat);
    check_eq("stall_lat", 32'(lat), 32'd6);
    check_eq("stall_f0", 32'(f), 32'd5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("stall_bcd_start", 32'(bcd_start), 32'd0);
      check_eq("stall_ready", 32'(ready), 32'd0);
      i     = 5'd3;
      start = (k % 2 == 0);
    end
    @(negedge clk);
    start = 1'b0;
    check_eq("stall_f_hold", 32'(f), 32'd5);
    check_eq("stall_no_done", 32'(done_tick), 32'd0);
    bcd_ready = 1'b1;
    #1;
    check_eq("stall_bcd_start_on", 32'(bcd_start), 32'd1);
    @(negedge clk);
    check_eq("stall_ready_back", 32'(ready), 32'd1);
    check_eq("stall_bcd_start_off", 32'(bcd_start), 32'd0);
    check_eq("stall_f_final", 32'(f), 32'd5);

    // Reset in the middle of a long computation.
    @(negedge clk);
    i     = 5'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("midop_busy", 32'(ready), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("midop_ready", 32'(ready), 32'd1);
    check_eq("midop_f", 32'(f), 32'd0);
    check_eq("midop_done", 32'(done_tick), 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done_tick || bcd_start) pulses++;
    end
    check_eq("midop_no_pulses", 32'(pulses), 32'd0);
    run_case("i5", 5'd5, 15'd5, 1'b0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
